// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one program ROM between the instruction-fetch port (port 0) and a
//   data/debug read port (port 1). One requester is granted per cycle; the
//   winner's address is registered onto the ROM, and the ROM word is returned
//   to the winning port two cycles after the grant.
//
// Parameters
//   ADDR_W     ROM word-address width (depth 2**ADDR_W)
//   DATA_W     ROM word width
//   FIXED_PRIO 0 = round-robin on ties, 1 = port 0 always wins ties
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req0/addr0        port 0 request and word address
//   gnt0              port 0 accepted this cycle (combinational)
//   rvalid0/rdata0    port 0 one-cycle response pulse and held read data
//   req1 .. rdata1    same set for port 1
//   rom_addr/rom_sel  registered ROM address and select
//   rom_data          combinational ROM read data
module rom_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_sel,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Issue stage
    port_e             last_q, last_d;
    port_e             own_q, own_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_sel_q, rom_sel_d;

    // Response stage
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    // Arbitration. Grants are suppressed during reset so nothing issued in
    // the reset cycle can produce a response afterwards.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                // On a tie the port that did not win last time goes next,
                // unless port 0 has fixed priority.
                if (FIXED_PRIO || (last_q == PORT1)) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Issue stage next state
    always_comb begin
        last_d     = last_q;
        own_d      = own_q;
        vld_d      = 1'b0;
        rom_sel_d  = 1'b0;
        rom_addr_d = rom_addr_q;
        if (gnt0) begin
            last_d     = PORT0;
            own_d      = PORT0;
            vld_d      = 1'b1;
            rom_sel_d  = 1'b1;
            rom_addr_d = addr0;
        end else if (gnt1) begin
            last_d     = PORT1;
            own_d      = PORT1;
            vld_d      = 1'b1;
            rom_sel_d  = 1'b1;
            rom_addr_d = addr1;
        end
    end

    // Response stage next state: the ROM word read in the cycle after the
    // grant is steered to the owning port; the other port's data holds.
    always_comb begin
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (vld_q) begin
            if (own_q == PORT0) begin
                rvalid0_d = 1'b1;
                rdata0_d  = rom_data;
            end else begin
                rvalid1_d = 1'b1;
                rdata1_d  = rom_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= PORT1;
            own_q      <= PORT0;
            vld_q      <= 1'b0;
            rom_sel_q  <= 1'b0;
            rom_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            last_q     <= last_d;
            own_q      <= own_d;
            vld_q      <= vld_d;
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_sel  = rom_sel_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(gnt0 && gnt1));
            assert (!(gnt0 && !req0));
            assert (!(gnt1 && !req1));
        end
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and read sequencer for the shared 1024×32 program ROM. It lets the instruction-fetch port and a secondary data/debug read port share the single ROM. It picks one requester per cycle and drives the ROM address and select from registers. It returns the ROM word to the winning port with fixed latency. It sits between the fetch stage / load path and the ROM instance, and owns the ROM `addr` and `sel` inputs exclusively.

## Interface
- `ADDR_W`, default 10: ROM word-address width; ROM depth is 2**ADDR_W.
- `DATA_W`, default 32: ROM word width.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes port 0 always win ties.

Ports:
- `clk` input 1: single clock; every register updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: port 0 (instruction fetch) read request.
- `addr0` input ADDR_W: port 0 word address; must be stable while `req0` is high and `gnt0` is low.
- `gnt0` output 1: combinational; the request is accepted this cycle.
- `rvalid0` output 1: one-cycle pulse; `rdata0` is new this cycle.
- `rdata0` output DATA_W: returned word; holds until the next port-0 response.
- `req1`, `addr1`, `gnt1`, `rvalid1`, `rdata1`: identical set for port 1 (data/debug).
- `rom_addr` output ADDR_W: registered ROM address.
- `rom_sel` output 1: registered ROM select.
- `rom_data` input DATA_W: combinational ROM read data; 0 when `rom_sel` is low.

## Operation
- **Arbitration (combinational):**
  - Only one request high: that port is granted.
  - Both requests high: with `FIXED_PRIO`=1, port 0 wins. With `FIXED_PRIO`=0, the port not recorded in `last_q` wins.
  - At most one `gnt` is high per cycle. `gnt` never rises without its `req`.
- **`last_q` register:** updated to the granted port on every grant, including single-requester grants. Reset value is 1, so port 0 wins the first tie.
- **Issue stage:**
  - On a grant, register `rom_addr` ← winner's address, `rom_sel` ← 1, `own_q` ← winner index, `vld_q` ← 1.
  - With no grant: `rom_sel` ← 0, `vld_q` ← 0, and `rom_addr` holds its previous value.
- **Response stage:**
  - When `vld_q` is 1, capture `rom_data` into `rdata[own_q]`.
  - Pulse `rvalid[own_q]` the following cycle. The other port's `rdata` is untouched.
- **Pipeline:**
  - Fully pipelined, one grant per cycle.
  - No backpressure: requesters must accept `rvalid` when it arrives.
  - Back-to-back grants to the same port return in order.
- **Request withdrawal:** a requester may drop `req` before it is granted. No state changes and no response is produced.
- **Out-of-range addresses:** none are possible, because the address is ADDR_W bits and the full ROM is covered.

## Timing
- **Reset values:** `gnt0/1`=0, `rvalid0/1`=0, `rdata0/1`=0, `rom_addr`=0, `rom_sel`=0, `vld_q`=0, `own_q`=0, `last_q`=1.
- **Latency:**
  - Grant in cycle N.
  - `rom_addr`/`rom_sel` valid in N+1.
  - `rvalid`/`rdata` visible in N+2.
- **Throughput:** one read per cycle across both ports. Under continuous dual requests in round-robin mode, each port gets every other cycle.
- **Reset mid-operation:**
  - Reset asserted in any cycle discards in-flight issue and response stages.
  - No `rvalid` appears in the cycle after reset deasserts, nor from a grant made in the reset cycle.
  - `gnt` is forced low while `rst`=1.
- **Priority corner:** with `FIXED_PRIO`=1 and `req0` held continuously, port 1 starves. This is accepted by design; it is used only for the debug-halt configuration.

## Test plan
Bench ROM model: rom[a] = 32'hA5A5_0000 | a.
1. **Single port:** reset, then `req0`=1, `addr0`=10'h004 for one cycle → `gnt0`=1 in the same cycle; `rom_sel`=1 and `rom_addr`=10'h004 next cycle; `rvalid0`=1 with `rdata0`=32'hA5A5_0004 two cycles after the grant; `rvalid1` stays 0.
2. **Round-robin tie:** `req0` and `req1` both held high, `addr0`=10'h010, `addr1`=10'h020, for 4 cycles → grants go 0,1,0,1; `rdata0`=32'hA5A5_0010 and `rdata1`=32'hA5A5_0020 alternate, each `rvalid` pulsing every other cycle from cycle N+2.
3. **Fixed priority:** with `FIXED_PRIO`=1, repeat scenario 2 → `gnt0`=1 every cycle, `gnt1` never rises, and `rvalid0` is high for 4 consecutive cycles.
4. **Back-to-back same port:** `req1` with `addr1`=10'h3FF then 10'h000 in consecutive cycles → `rdata1` is 32'hA5A5_03FF then 32'hA5A5_0000 on consecutive `rvalid1` pulses.
5. **Reset mid-flight:** grant port 0 at 10'h055, assert `rst` in the next cycle → no `rvalid0` at any time, `rdata0` remains 0, and `rom_sel`=0 after reset.
6. **Withdrawal:** `req1` asserted while `req0` wins under fixed priority, then `req1` dropped → no `gnt1`, no `rvalid1`, and `rdata1` unchanged.
